// File: rtl/glitch_free_demux_pkg.sv
// rtl/glitch_free_demux_pkg.sv - shared types and sizing helpers for glitch_free_demux
//
// Purpose:
//   Routing FSM state encoding and the gap-counter width helper used by the
//   top level.
//
// Contents:
//   state_t        : S_ROUTE (steering beats), S_DRAIN (emptying the output
//                    register on the old route), S_GAP (both outputs idle
//                    before the route flips).
//   gap_cnt_width  : counter width needed to hold GAP_CYCLES-1.
//   SYNC_STAGES_MIN: shortest legal synchronizer chain.
//   GAP_CYCLES_MIN : shortest legal dead gap.

package glitch_free_demux_pkg;

   typedef enum logic [1:0] {
      S_ROUTE = 2'd0,
      S_DRAIN = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int GAP_CYCLES_MIN  = 1;

   // One extra bit over $clog2 so GAP_CYCLES=1 still yields a 1-bit counter.
   function automatic int gap_cnt_width(input int gap_cycles);
      return $clog2(gap_cycles) + 1;
   endfunction

endpackage

// File: rtl/glitch_free_demux_sync.sv
// rtl/glitch_free_demux_sync.sv - multi-flop synchronizer for a single asynchronous bit
//
// Purpose:
//   Brings an asynchronous level into the clk domain through a chain of
//   STAGES flops. Usable for any slow-changing async control input.
//
// Parameters:
//   STAGES   : number of flops in the chain (at least 2).
//
// Ports:
//   clk      : in  clock, rising edge.
//   rst      : in  asynchronous active-low reset, clears the whole chain.
//   async_in : in  asynchronous input level.
//   sync_out : out synchronized level, STAGES clocks behind async_in.

module glitch_free_demux_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] chain_q;

   // Bit 0 is the metastability-catching flop; the oldest bit is the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], async_in};
      end
   end

   assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/glitch_free_demux.sv
// rtl/glitch_free_demux.sv - 1-to-2 valid/ready stream demux with break-before-make switching
//
// Purpose:
//   Steers one valid/ready producer to one of two consumers. The route
//   request `select` is asynchronous; a change is synchronized, the single
//   output register is drained on the old route, both outputs sit idle for
//   GAP_CYCLES cycles, and only then does the committed route flip. A beat
//   is never split across routes and a valid never appears on the wrong
//   output.
//
// Parameters:
//   WIDTH       : data width in bits.
//   SYNC_STAGES : flops synchronizing `select` (>= 2).
//   GAP_CYCLES  : idle cycles between drain and route flip (>= 1).
//
// Ports:
//   clk          : in  clock, rising edge.
//   rst          : in  asynchronous active-low reset.
//   select       : in  async route request, 0 = out0, 1 = out1.
//   in_data      : in  input beat.
//   in_valid     : in  input beat valid.
//   in_ready     : out input beat accepted when in_valid & in_ready.
//   out0_data    : out output 0 data.
//   out0_valid   : out output 0 valid.
//   out0_ready   : in  output 0 ready.
//   out1_data    : out output 1 data.
//   out1_valid   : out output 1 valid.
//   out1_ready   : in  output 1 ready.
//   active_sel   : out currently committed route.
//   switching    : out high while draining or in the dead gap.
//
// Build option GLITCH_FREE_DEMUX_STATS_EN adds:
//   switch_count : out [15:0] committed route flips, wraps.
//   abort_count  : out [7:0]  drains abandoned because select bounced back,
//                             saturates at 8'hFF.

module glitch_free_demux
   import glitch_free_demux_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int GAP_CYCLES  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             select,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic             active_sel,
   output logic             switching
`ifdef GLITCH_FREE_DEMUX_STATS_EN
   ,
   output logic [15:0]      switch_count,
   output logic [7:0]       abort_count
`endif
);

   localparam int             CNT_W    = gap_cnt_width(GAP_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               active_q;
   logic               flip;

   logic               sync_sel;
   logic               mismatch;

   logic [WIDTH-1:0]   data_q;
   logic               valid_q;
   logic               cur_ready;
   logic               accept;
   logic               out_hs;

   // ------------------------------------------------------------------
   // Route request synchronizer
   // ------------------------------------------------------------------
   glitch_free_demux_sync #(
      .STAGES   (SYNC_STAGES)
   ) u_sel_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (select),
      .sync_out (sync_sel)
   );

   assign mismatch = sync_sel ^ active_q;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_ROUTE;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         if (flip) begin
            active_q <= ~active_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flip    = 1'b0;
      case (state_q)
         S_ROUTE: begin
            if (mismatch) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // An empty register wins over a bounced select: once nothing is
            // pending the switch is committed.
            if (!valid_q) begin
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
            end else if (!mismatch) begin
               state_d = S_ROUTE;
            end
         end
         S_GAP: begin
            // Committed: select activity is ignored until the flip.
            if (cnt_q == '0) begin
               state_d = S_ROUTE;
               flip    = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_ROUTE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      cur_ready = active_q ? out1_ready : out0_ready;
      // Accepting is only allowed while routing on an agreed route; the
      // reset term keeps in_ready low for the whole reset window.
      in_ready   = rst & (state_q == S_ROUTE) & ~mismatch & (~valid_q | cur_ready);
      // valid_q is always clear in S_GAP, so both valids are idle there.
      out0_valid = valid_q & ~active_q;
      out1_valid = valid_q &  active_q;
      switching  = (state_q != S_ROUTE);
   end

   assign out0_data  = data_q;
   assign out1_data  = data_q;
   assign active_sel = active_q;

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   assign accept = in_valid & in_ready;
   assign out_hs = valid_q & cur_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (accept) begin
         // Covers accept-with-handshake too: the register refills in the
         // same cycle it empties, giving one beat per cycle.
         valid_q <= 1'b1;
         data_q  <= in_data;
      end else if (out_hs) begin
         valid_q <= 1'b0;
      end
   end

`ifdef GLITCH_FREE_DEMUX_STATS_EN
   // ------------------------------------------------------------------
   // Switch statistics
   // ------------------------------------------------------------------
   logic abort;

   assign abort = (state_q == S_DRAIN) & valid_q & ~mismatch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         switch_count <= '0;
         abort_count  <= '0;
      end else begin
         if (flip) begin
            switch_count <= switch_count + 16'd1;
         end
         if (abort && (abort_count != 8'hFF)) begin
            abort_count <= abort_count + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_glitch_free_demux.sv
// tb/tb_glitch_free_demux.sv - self-checking bench for glitch_free_demux
//
// Directed tables and sequences for reset, streaming, clean switch, drain
// under backpressure, bounce abort and reset during the gap, then random
// traffic compared every cycle against a transaction-level reference model.

module tb_glitch_free_demux;

   localparam int WIDTH = 8;
   localparam int SYNC  = 2;
   localparam int GAP   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             select = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready = 1'b0;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready = 1'b0;
   logic             active_sel;
   logic             switching;
`ifdef GLITCH_FREE_DEMUX_STATS_EN
   logic [15:0]      switch_count;
   logic [7:0]       abort_count;
`endif

   int checks = 0;
   int errors = 0;

   glitch_free_demux #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .select      (select),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out0_data   (out0_data),
      .out0_valid  (out0_valid),
      .out0_ready  (out0_ready),
      .out1_data   (out1_data),
      .out1_valid  (out1_valid),
      .out1_ready  (out1_ready),
      .active_sel  (active_sel),
      .switching   (switching)
`ifdef GLITCH_FREE_DEMUX_STATS_EN
      ,
      .switch_count(switch_count),
      .abort_count (abort_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Comparison helpers
   // ------------------------------------------------------------------
   function automatic void chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_idle(input string tag);
      chk1({tag, "_in_ready"},   in_ready,   1'b0);
      chk1({tag, "_out0_valid"}, out0_valid, 1'b0);
      chk1({tag, "_out1_valid"}, out1_valid, 1'b0);
      chk1({tag, "_active_sel"}, active_sel, 1'b0);
      chk1({tag, "_switching"},  switching,  1'b0);
   endfunction

   // ------------------------------------------------------------------
   // Reference model: a route, a one-entry beat queue, a history of the
   // select input standing in for the synchronizer, and a phase number
   // (0 routing, 1 waiting for the queue to empty, 2 dead gap).
   // ------------------------------------------------------------------
   bit               m_route;
   int               m_phase;
   int               m_gap_left;
   logic [WIDTH-1:0] m_buf[$];
   bit               m_hist[$];
   bit               p_v0, p_v1, p_r0, p_r1;
   logic [WIDTH-1:0] p_d;

   function automatic void model_reset();
      m_route    = 1'b0;
      m_phase    = 0;
      m_gap_left = 0;
      m_buf.delete();
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      p_v0 = 1'b0;
      p_v1 = 1'b0;
      p_r0 = 1'b0;
      p_r1 = 1'b0;
      p_d  = '0;
   endfunction

   // Check the current cycle's outputs, then advance to the next edge.
   function automatic void model_step();
      bit sync, mis, cr, rdy, has, acc, hs;
      sync = m_hist[SYNC-1];
      mis  = (sync != m_route);
      cr   = m_route ? out1_ready : out0_ready;
      has  = (m_buf.size() != 0);
      rdy  = (m_phase == 0) && !mis && (!has || cr);

      chk1("m_in_ready",   in_ready,   rdy);
      chk1("m_out0_valid", out0_valid, has && (m_route == 1'b0));
      chk1("m_out1_valid", out1_valid, has && (m_route == 1'b1));
      if (has && !m_route) chk8("m_out0_data", out0_data, m_buf[0]);
      if (has &&  m_route) chk8("m_out1_data", out1_data, m_buf[0]);
      chk1("m_active_sel", active_sel, m_route);
      chk1("m_switching",  switching,  m_phase != 0);
      chk1("m_one_hot",    out0_valid & out1_valid, 1'b0);
      if (p_v0 && !p_r0) begin
         chk1("hold0_valid", out0_valid, 1'b1);
         chk8("hold0_data",  out0_data,  p_d);
      end
      if (p_v1 && !p_r1) begin
         chk1("hold1_valid", out1_valid, 1'b1);
         chk8("hold1_data",  out1_data,  p_d);
      end

      p_v0 = has && !m_route;
      p_v1 = has &&  m_route;
      p_r0 = out0_ready;
      p_r1 = out1_ready;
      p_d  = has ? m_buf[0] : '0;

      acc = in_valid && rdy;
      hs  = has && cr;
      case (m_phase)
         0: if (mis) m_phase = 1;
         1: begin
            if (!has) begin
               m_phase    = 2;
               m_gap_left = GAP - 1;
            end else if (!mis) begin
               m_phase = 0;
            end
         end
         default: begin
            if (m_gap_left == 0) begin
               m_route = ~m_route;
               m_phase = 0;
            end else begin
               m_gap_left--;
            end
         end
      endcase
      if (hs)  void'(m_buf.pop_front());
      if (acc) m_buf.push_back(in_data);
      m_hist.push_front(select);
      void'(m_hist.pop_back());
   endfunction

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic cyc(input bit s, input bit iv, input logic [7:0] d, input bit r0, input bit r1);
      @(negedge clk);
      select     = s;
      in_valid   = iv;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      #1;
      model_step();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic do_reset(input bit s);
      @(negedge clk);
      rst        = 1'b0;
      select     = s;
      in_valid   = 1'b0;
      in_data    = '0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      #1;
      chk_idle("rst");
      model_reset();
      release_reset();
   endtask

   typedef struct {
      bit               sel;
      bit               iv;
      logic [WIDTH-1:0] d;
      bit               r0;
      bit               r1;
      bit               e_rdy;
      bit               e_v0;
      bit               e_v1;
      bit               e_act;
      bit               e_sw;
      logic [WIDTH-1:0] e_data;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n;
      int sw_seen;
      bit s;

      // Clean switch 0 -> 1 with idle input: flip six cycles after select.
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[7] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C};
      tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

      // Reset held with traffic and select=1 pending.
      rst        = 1'b0;
      select     = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h77;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk_idle("hold_rst");
      end
      model_reset();
      release_reset();
      cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
      chk1("post_rst_in_ready", in_ready, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      chk1("post_rst_out0_valid", out0_valid, 1'b1);
      chk8("post_rst_out0_data",  out0_data,  8'h77);
      chk1("post_rst_out1_valid", out1_valid, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      chk1("post_rst_route_1", active_sel, 1'b1);

      // Streaming 01..10 on out0.
      do_reset(1'b0);
      for (int i = 0; i <= 16; i++) begin
         cyc(1'b0, i < 16, 8'(i + 1), 1'b1, 1'b0);
         if (i < 16) chk1("stream_in_ready", in_ready, 1'b1);
         if (i > 0) begin
            chk1("stream_out0_valid", out0_valid, 1'b1);
            chk8("stream_out0_data",  out0_data,  8'(i));
            chk1("stream_out1_valid", out1_valid, 1'b0);
         end
      end

      // Clean switch table.
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].sel, tbl[i].iv, tbl[i].d, tbl[i].r0, tbl[i].r1);
         chk1("tbl_in_ready",   in_ready,   tbl[i].e_rdy);
         chk1("tbl_out0_valid", out0_valid, tbl[i].e_v0);
         chk1("tbl_out1_valid", out1_valid, tbl[i].e_v1);
         chk1("tbl_active_sel", active_sel, tbl[i].e_act);
         chk1("tbl_switching",  switching,  tbl[i].e_sw);
         if (tbl[i].e_v1) chk8("tbl_out1_data", out1_data, tbl[i].e_data);
         if (tbl[i].e_v0) chk8("tbl_out0_data", out0_data, tbl[i].e_data);
      end

      // Drain with backpressure.
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      chk1("drain_accept", in_ready, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
         chk1("drain_out0_valid", out0_valid, 1'b1);
         chk8("drain_out0_data",  out0_data,  8'hA5);
         chk1("drain_in_ready",   in_ready,   1'b0);
         chk1("drain_out1_valid", out1_valid, 1'b0);
      end
      chk1("drain_switching", switching, 1'b1);
      cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
      chk1("drain_hs_valid", out0_valid, 1'b1);
      chk1("drain_hs_in_ready", in_ready, 1'b0);
      n = 0;
      while (n < 12) begin
         cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
         n++;
         chk1("drain_gap_out0_valid", out0_valid, 1'b0);
         if (in_ready) break;
      end
      chk_int("drain_cycles_to_ready", n, GAP + 2);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      chk1("drain_out1_valid_new", out1_valid, 1'b1);
      chk8("drain_out1_data_new",  out1_data,  8'h5A);
      chk1("drain_out0_quiet",     out0_valid, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

      // Bounce: one-cycle select pulse while a beat is stuck on out0.
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      sw_seen = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
         if (switching) sw_seen++;
         chk1("bounce_active_sel", active_sel, 1'b0);
         chk1("bounce_out0_hold",  out0_valid, 1'b1);
      end
      chk_int("bounce_switching_cycles", sw_seen, 1);
`ifdef GLITCH_FREE_DEMUX_STATS_EN
      chk_int("bounce_abort_count",  int'(abort_count),  1);
      chk_int("bounce_switch_count", int'(switch_count), 0);
`endif
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Reset asserted in the middle of the gap.
      do_reset(1'b0);
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      chk1("gap_before_rst", switching, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk_idle("gap_rst");
      model_reset();
      release_reset();

      // Random traffic against the model.
      s = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) s = ~s;
         if ($urandom_range(0, 99) == 0) begin
            cyc(~s, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 7);
         end else begin
            cyc(s, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 7);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
